pipelined_execution_alu: RTL
============================

// Module: pipelined_execution_alu
// PURPOSE
//  Parametrised successor ALU for RV32I/RV64I integer ops (OP, OP-IMM, JAL/JALR link, AUIPC, LUI).
//  Adds a registered result stage with valid/ready handshake and an optional iterative shifter.
//  Operand bypass muxing is built in.
//  Sits between Instruction_Decoder/Control_Unit (issue side) and the writeback/forward network.
// PARAMETERS
//  XLEN          32  datapath width (32 or 64); shamt width SW = $clog2(XLEN)
//  SERIAL_SHIFT  0   0: single-cycle barrel shift; 1: shift 1 bit/cycle via sub-module
//  TAG_W         5   width of opaque tag (rd index) carried alongside each op
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      asynchronous, active-low reset
//  in_valid     in   1      issue side presents an op
//  in_ready     out  1      unit accepts op this cycle
//  opcode       in   7      RV opcode
//  funct3       in   3      RV funct3
//  funct7       in   7      RV funct7 (bit5 selects SUB/SRA/SRAI)
//  mux1_select  in   2      op1: 00 rs1, 01 fwd1, 10 PC, 11 zero (LUI)
//  mux2_select  in   2      op2: 00 rs2, 01 fwd2, 10 imm, 11 const 4
//  pc           in   XLEN   program counter
//  bus_rs1      in   XLEN   register source 1
//  bus_rs2      in   XLEN   register source 2
//  immediate    in   XLEN   sign-extended immediate
//  forward_rs1  in   XLEN   bypass data 1
//  forward_rs2  in   XLEN   bypass data 2
//  in_tag       in   TAG_W  tag captured with the op
//  out_valid    out  1      result valid
//  out_ready    in   1      consumer accepts result
//  alu_output   out  XLEN   result
//  out_tag      out  TAG_W  tag of result
//  illegal_op   out  1      qualified by out_valid; undecodable opcode/funct combo
// BEHAVIOUR
//  Reset (async, reset==0): out_valid=0, alu_output=0, out_tag=0, illegal_op=0, FSM=IDLE, cnt=0.
//  Handshake: transfer on valid&&ready at posedge; in_valid/data must be held until accepted.
//    Output stays stable while out_valid && !out_ready.
//  in_ready = (state==IDLE) && (!out_valid || out_ready)   // one-deep output register, no skid
//  Non-shift ops: latency 1; accepted at edge N -> out_valid high after edge N; back-to-back
//    throughput 1/cycle while out_ready=1.
//  Ops: ADD/ADDI/JAL/JALR/AUIPC/LUI = op1+op2; SUB = op1-op2; SLT(I) signed, SLTU(I) unsigned
//    -> result {XLEN-1 zeros, bit}.
//    XOR/OR/AND(I) bitwise.
//    SLL/SRL/SRA(I): shamt = op2[SW-1:0]; SRA sign-fills from op1[XLEN-1] (arithmetic).
//    SRAI/SRLI distinguished by funct7[5]; for XLEN=64 funct7[0] is shamt[5], ignored in decode.
//  Undecodable combo: still accepted, result 0, illegal_op=1 with the result (no hang).
//  FSM (only SERIAL_SHIFT=1; otherwise permanently IDLE):
//    IDLE  -> SHIFT on accepted shift op with shamt!=0; load acc=op1, cnt=shamt
//    IDLE  -> (result reg) on shift with shamt==0; latency 1 like other ops, result op1
//    SHIFT: each cycle acc shifts 1 bit, cnt--; in_ready=0
//    SHIFT -> DONE when cnt==1 after that shift
//    DONE: load output reg when !out_valid||out_ready, -> IDLE
//    Shift latency = shamt+1 cycles when consumer ready.
//  Wrap/width: all arithmetic mod 2^XLEN, carries dropped; shamt upper bits of op2 ignored.
//  Simultaneous: result drain and new accept in same cycle is legal (in_ready covers it).
//  Reset mid-shift: FSM aborts to IDLE, op is lost, out_valid=0 immediately (async).
// STRUCTURE
//  Package alu_pkg: opcode localparams (OP_IMM, OP, JAL, JALR, AUIPC, LUI), funct3 codes,
//    alu_op_t enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS, ILLEGAL),
//    mux select codes, fsm_state_t {IDLE, SHIFT, DONE}.
//  Sub-module serial_shifter (XLEN): start/shamt/dir/arith in, busy/done/result out;
//    instantiated only under generate SERIAL_SHIFT==1.
//  Decode is a combinational function to alu_op_t, feeding a registered result stage.
// TESTING
//  1 ADD rs1=32'h7FFF_FFFF, rs2=1, out_ready=1 -> next cycle out_valid=1, 32'h8000_0000; no flag.
//  2 SRA op1=32'hF000_0000, shamt=4:
//    SERIAL_SHIFT=0 -> 32'hFF00_0000 at latency 1;
//    SERIAL_SHIFT=1 -> same value, in_ready low 4 cycles, latency 5.
//  3 SLTU 1 vs 32'hFFFF_FFFF -> 1; SLT same operands -> 0;
//    SUB 0-1 -> 32'hFFFF_FFFF (wrap).
//  4 Backpressure: 3 ADDs streamed with out_ready=0 for 3 cycles ->
//    1st result held stable, in_ready=0; then 1 result/cycle in order, tags preserved.
//  5 opcode=7'b1111111 -> accepted, alu_output=0, illegal_op=1;
//    next legal op -> illegal_op=0.
//  6 reset low during SHIFT (shamt=20, cycle 5) -> out_valid=0 at once;
//    after release in_ready=1, next ADD 2+3 -> 5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the pipelined execution ALU: RV opcodes, funct3 codes,
// operand select codes, internal op and FSM enums, and the op decoder.
package alu_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLT     = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_XOR     = 3'd4;
    localparam logic [2:0] F3_SR      = 3'd5;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;

    localparam logic [1:0] SEL1_RS1  = 2'b00;
    localparam logic [1:0] SEL1_FWD  = 2'b01;
    localparam logic [1:0] SEL1_PC   = 2'b10;
    localparam logic [1:0] SEL1_ZERO = 2'b11;
    localparam logic [1:0] SEL2_RS2  = 2'b00;
    localparam logic [1:0] SEL2_FWD  = 2'b01;
    localparam logic [1:0] SEL2_IMM  = 2'b10;
    localparam logic [1:0] SEL2_FOUR = 2'b11;

    typedef enum logic [3:0] {
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS, ILLEGAL
    } alu_op_t;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} fsm_state_t;

    // For RV64 funct7[0] carries shamt[5] on immediate shifts, so it is not part of the decode.
    function automatic alu_op_t decode_op(input logic [6:0] opcode, input logic [2:0] funct3,
                                          input logic [6:0] funct7, input logic rv64);
        alu_op_t op;
        logic    shamt_hi_ok;
        op          = ILLEGAL;
        shamt_hi_ok = rv64 || !funct7[0];
        case (opcode)
            LUI, AUIPC, JAL, JALR: op = ADD;
            OP_IMM: begin
                case (funct3)
                    F3_ADD_SUB: op = ADD;
                    F3_SLT:     op = SLT;
                    F3_SLTU:    op = SLTU;
                    F3_XOR:     op = XOR;
                    F3_OR:      op = OR;
                    F3_AND:     op = AND;
                    F3_SLL: if (funct7[6:1] == 6'd0 && shamt_hi_ok) op = SLL;
                    F3_SR: begin
                        if ({funct7[6], funct7[4:1]} == 5'd0 && shamt_hi_ok)
                            op = funct7[5] ? SRA : SRL;
                    end
                    default: op = ILLEGAL;
                endcase
            end
            OP: begin
                if (funct7 == 7'h00) begin
                    case (funct3)
                        F3_ADD_SUB: op = ADD;
                        F3_SLL:     op = SLL;
                        F3_SLT:     op = SLT;
                        F3_SLTU:    op = SLTU;
                        F3_XOR:     op = XOR;
                        F3_SR:      op = SRL;
                        F3_OR:      op = OR;
                        F3_AND:     op = AND;
                        default:    op = ILLEGAL;
                    endcase
                end else if (funct7 == 7'h20) begin
                    if (funct3 == F3_ADD_SUB) op = SUB;
                    else if (funct3 == F3_SR) op = SRA;
                end
            end
            default: op = ILLEGAL;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/serial_shifter.sv
// One-bit-per-cycle shifter. The first bit moves on the start edge, so cnt holds
// the shifts still outstanding and done flags the cycle of the final shift.
module serial_shifter #(
    parameter int XLEN = 32,
    parameter int SW   = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [SW-1:0]   shamt,
    input  logic            dir,
    input  logic            arith,
    input  logic [XLEN-1:0] operand,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] acc;
    logic [SW-1:0]   cnt;
    logic            dir_q;
    logic            arith_q;

    // dir=1 shifts left; arith fills right shifts with the sign bit.
    function automatic logic [XLEN-1:0] step(input logic [XLEN-1:0] x, input logic left,
                                             input logic ar);
        if (left) return {x[XLEN-2:0], 1'b0};
        return {ar & x[XLEN-1], x[XLEN-1:1]};
    endfunction

    assign busy   = (cnt != '0);
    assign done   = (cnt == SW'(1));
    assign result = acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc     <= '0;
            cnt     <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
        end else if (start) begin
            acc     <= step(operand, dir, arith);
            cnt     <= shamt - SW'(1);
            dir_q   <= dir;
            arith_q <= arith;
        end else if (busy) begin
            acc <= step(acc, dir_q, arith_q);
            cnt <= cnt - SW'(1);
        end
    end

endmodule

// File: rtl/pipelined_execution_alu.sv
// RV32I/RV64I integer execution unit: operand bypass muxes, decode, one-deep
// registered result stage with valid/ready, optional serial shifter.
module pipelined_execution_alu
    import alu_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int SERIAL_SHIFT = 0,
    parameter int TAG_W        = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [1:0]       mux1_select,
    input  logic [1:0]       mux2_select,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  bus_rs1,
    input  logic [XLEN-1:0]  bus_rs2,
    input  logic [XLEN-1:0]  immediate,
    input  logic [XLEN-1:0]  forward_rs1,
    input  logic [XLEN-1:0]  forward_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  alu_output,
    output logic [TAG_W-1:0] out_tag,
    output logic             illegal_op,
    output fsm_state_t       dbg_state
);

    localparam int SW = $clog2(XLEN);

    logic [XLEN-1:0]  op1, op2, comb_result;
    logic [SW-1:0]    shamt;
    alu_op_t          op;
    logic             is_shift, use_serial, accept;
    fsm_state_t       state, state_nxt;
    logic [TAG_W-1:0] pend_tag;
    logic             sh_busy, sh_done;
    logic [XLEN-1:0]  sh_result;

    always_comb begin
        op1 = bus_rs1;
        case (mux1_select)
            SEL1_RS1: op1 = bus_rs1;
            SEL1_FWD: op1 = forward_rs1;
            SEL1_PC:  op1 = pc;
            default:  op1 = '0;
        endcase
        op2 = bus_rs2;
        case (mux2_select)
            SEL2_RS2: op2 = bus_rs2;
            SEL2_FWD: op2 = forward_rs2;
            SEL2_IMM: op2 = immediate;
            default:  op2 = XLEN'(4);
        endcase
    end

    assign shamt      = op2[SW-1:0];
    assign op         = decode_op(opcode, funct3, funct7, XLEN == 64);
    assign is_shift   = (op == SLL) || (op == SRL) || (op == SRA);
    assign use_serial = (SERIAL_SHIFT != 0) && is_shift && (shamt != '0);

    // Handshake: an op transfers on in_valid && in_ready at posedge and its fields must be
    // held until then; a result transfers on out_valid && out_ready and is held stable until then.
    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign dbg_state = state;

    always_comb begin
        comb_result = '0;
        case (op)
            ADD:  comb_result = op1 + op2;
            SUB:  comb_result = op1 - op2;
            SLT:  comb_result = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
            SLTU: comb_result = {{(XLEN-1){1'b0}}, (op1 < op2)};
            XOR:  comb_result = op1 ^ op2;
            OR:   comb_result = op1 | op2;
            AND:  comb_result = op1 & op2;
            PASS: comb_result = op1;
            // In serial mode only a zero shift reaches this path, whose result is op1.
            SLL: begin
                if (SERIAL_SHIFT != 0) comb_result = op1;
                else                   comb_result = op1 << shamt;
            end
            SRL: begin
                if (SERIAL_SHIFT != 0) comb_result = op1;
                else                   comb_result = op1 >> shamt;
            end
            SRA: begin
                if (SERIAL_SHIFT != 0) comb_result = op1;
                else                   comb_result = $signed(op1) >>> shamt;
            end
            default: comb_result = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept && use_serial) state_nxt = (shamt == SW'(1)) ? DONE : SHIFT;
            SHIFT: begin
                if (sh_done)       state_nxt = DONE;
                else if (!sh_busy) state_nxt = IDLE;
            end
            DONE:  if (!out_valid || out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            alu_output <= '0;
            out_tag    <= '0;
            illegal_op <= 1'b0;
            pend_tag   <= '0;
        end else begin
            state <= state_nxt;
            if (accept && use_serial) pend_tag <= in_tag;
            if (accept && !use_serial) begin
                out_valid  <= 1'b1;
                alu_output <= comb_result;
                out_tag    <= in_tag;
                illegal_op <= (op == ILLEGAL);
            end else if (state == DONE && (!out_valid || out_ready)) begin
                out_valid  <= 1'b1;
                alu_output <= sh_result;
                out_tag    <= pend_tag;
                illegal_op <= 1'b0;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    if (SERIAL_SHIFT != 0) begin : g_serial
        serial_shifter #(.XLEN(XLEN), .SW(SW)) u_shifter (
            .clk     (clk),
            .reset   (reset),
            .start   (accept && use_serial),
            .shamt   (shamt),
            .dir     (op == SLL),
            .arith   (op == SRA),
            .operand (op1),
            .busy    (sh_busy),
            .done    (sh_done),
            .result  (sh_result)
        );
    end else begin : g_barrel
        assign sh_busy   = 1'b0;
        assign sh_done   = 1'b0;
        assign sh_result = '0;
    end

endmodule
